// File: rtl/texture_ram.sv
// Writable wall-texture store: registered read port plus a handshaked loader that fills one texture per session.
// Define TEXTURE_RAM_FILL_EN to paint a checkerboard into every texture after reset.
module texture_ram #(
  parameter int CHANNEL_BITS = 2,
  parameter int TEX_BITS     = 6,
  parameter int TEX_ID_BITS  = 1,
  localparam int TW          = 3 * CHANNEL_BITS
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   rd_en,
  input  logic [TEX_ID_BITS-1:0] rd_tex,
  input  logic [TEX_BITS-1:0]    rd_col,
  input  logic [TEX_BITS-1:0]    rd_row,
  output logic [TW-1:0]          rd_val,
  output logic                   rd_valid,
  input  logic                   load_start,
  input  logic [TEX_ID_BITS-1:0] load_tex,
  input  logic [TW-1:0]          load_data,
  input  logic                   load_valid,
  output logic                   load_ready,
  output logic                   load_busy,
  output logic                   load_done
);

  localparam int CW    = 2 * TEX_BITS;
  localparam int AW    = TEX_ID_BITS + CW;
  localparam int DEPTH = 2 ** AW;

`ifdef TEXTURE_RAM_FILL_EN
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_FILL} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;
`endif

  state_t                 state_q, state_d;
  logic [TEX_ID_BITS-1:0] base_q, base_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   we;
  logic [AW-1:0]          waddr;
  logic [TW-1:0]          wdata;
  logic [TW-1:0]          rd_val_q;
  logic                   rd_valid_q;
  logic [AW-1:0]          rd_addr;
  logic [TW-1:0]          mem [0:DEPTH-1];

`ifdef TEXTURE_RAM_FILL_EN
  logic [AW-1:0] fill_q, fill_d;
  logic          fill_bit;
  // Checkerboard of 32x32 tiles, inverted between even and odd textures.
  assign fill_bit = fill_q[TEX_BITS-1] ^ fill_q[CW-1] ^ fill_q[CW];
`endif

  assign rd_addr = {rd_tex, rd_col, rd_row};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
`ifdef TEXTURE_RAM_FILL_EN
      state_q <= S_FILL;
      fill_q  <= '0;
`else
      state_q <= S_IDLE;
`endif
      base_q  <= '0;
      cnt_q   <= '0;
    end else begin
`ifdef TEXTURE_RAM_FILL_EN
      fill_q  <= fill_d;
`endif
      state_q <= state_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    we      = 1'b0;
    waddr   = {base_q, cnt_q};
    wdata   = load_data;
`ifdef TEXTURE_RAM_FILL_EN
    fill_d  = fill_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          base_d  = load_tex;
          cnt_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (load_valid) begin
          we    = 1'b1;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == {CW{1'b1}}) state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
`ifdef TEXTURE_RAM_FILL_EN
      S_FILL: begin
        we     = 1'b1;
        waddr  = fill_q;
        wdata  = {TW{fill_bit}};
        fill_d = fill_q + AW'(1);
        if (fill_q == {AW{1'b1}}) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Writes are suppressed on a reset edge so an aborted session leaves no stray texel.
  always_ff @(posedge clk) begin
    if (we && reset_n) mem[waddr] <= wdata;
  end

  // Read-first: the array read sees the value from before this edge's write.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_val_q   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) begin
`ifdef TEXTURE_RAM_FILL_EN
        if (state_q == S_FILL) rd_val_q <= '0;
        else                   rd_val_q <= mem[rd_addr];
`else
        rd_val_q <= mem[rd_addr];
`endif
      end
    end
  end

  assign rd_val     = rd_val_q;
  assign rd_valid   = rd_valid_q;
  assign load_ready = (state_q == S_LOAD);
  assign load_busy  = (state_q != S_IDLE);
  assign load_done  = (state_q == S_DONE);

endmodule

// File: doc/texture_ram.md
Name: texture_ram

Overview:
- Synthesisable, writable wall-texture store. Replaces the sim-populated lookup table.
- Holds NUM_TEX square textures of 2^TEX_BITS x 2^TEX_BITS texels, each texel 3*CHANNEL_BITS wide (RGB).
- Registered read port feeds the row renderer. A handshaked streaming load port fills one whole texture per session from an external loader (SPI/host bridge).

Parameters:
- CHANNEL_BITS, 2, bits per colour channel; texel width TW = 3*CHANNEL_BITS.
- TEX_BITS, 6, log2 of texture edge; texture is 2^TEX_BITS cols x 2^TEX_BITS rows.
- TEX_ID_BITS, 1, log2 of texture count; NUM_TEX = 2^TEX_ID_BITS.
- Derived AW = TEX_ID_BITS + 2*TEX_BITS. Memory depth is 2^AW. Word address = {tex, col, row}, with row least significant.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous active-low reset.
- rd_en  in  1  read request this cycle.
- rd_tex  in  TEX_ID_BITS  texture index.
- rd_col  in  TEX_BITS  texel column.
- rd_row  in  TEX_BITS  texel row.
- rd_val  out  TW  texel data; holds until next accepted read.
- rd_valid  out  1  high one cycle after an accepted read.
- load_start  in  1  pulse: begin loading texture load_tex.
- load_tex  in  TEX_ID_BITS  target texture, sampled with load_start.
- load_data  in  TW  streamed texel.
- load_valid  in  1  load_data valid.
- load_ready  out  1  block accepts load_data this cycle.
- load_busy  out  1  high in any state other than IDLE.
- load_done  out  1  one-cycle pulse after final texel written.

Behaviour:
- Reset (reset_n low at edge): rd_val=0, rd_valid=0, load_ready=0, load_busy=0, load_done=0. The FSM goes to IDLE, or to FILL if the optional feature is enabled. The load counter clears. Memory contents are not cleared.
- Read, latency 1: rd_en sampled at edge N; rd_val/rd_valid update at edge N, visible in cycle N+1. rd_en low: rd_valid=0 next cycle and rd_val holds its value. Back-to-back reads give one result per cycle.
- Read/write collision on the same address in the same cycle: read-first (old data returned).
- FSM states: IDLE, LOAD, DONE, plus FILL when the optional feature is enabled.
- IDLE: load_ready=0.
  - load_start=1 latches load_tex into base, clears counter cnt (2*TEX_BITS wide), and moves to LOAD.
- LOAD: load_ready=1.
  - A beat transfers when load_valid & load_ready.
  - Each beat writes load_data to address {base, cnt} and increments cnt; row-fastest order, then col.
  - On the beat where cnt = all-ones: write it, then go to DONE. cnt wraps to 0.
  - No beat means no state change; stalls of any length are allowed.
- DONE: single cycle. load_done=1, load_ready=0, then go to IDLE.
- load_start is ignored outside IDLE, including in DONE.
- Reads are serviced in every state. A read of the texture being loaded returns a mix of old and new texels.
- Reset mid-LOAD aborts the session. Texels already written persist, and no load_done is issued.
- No bypass of load_data to rd_val.

Optional Feature:
- Macro: TEXTURE_RAM_FILL_EN.
- Defined:
  - Reset enters FILL; load_busy=1 and load_ready=0.
  - An AW-bit counter writes one word per cycle for 2^AW cycles, then goes to IDLE. No load_done pulse.
  - Pattern: texel = all-ones if (col[TEX_BITS-1]^row[TEX_BITS-1]^tex[0]), else 0.
  - rd_val is forced to 0 for reads accepted in FILL; rd_valid behaves normally.
  - Reset during FILL restarts FILL from address 0.
- Undefined: no FILL state. Reset goes to IDLE and contents are undefined until loaded.

Test Plan:
- Full load: load_start with load_tex=1, then 4096 beats with data = cnt[5:0], load_valid always 1. Expect load_done exactly one cycle after beat 4096 and load_busy low the next cycle. Reading tex=1,col=2,row=5 returns rd_val=6'd5 with rd_valid one cycle after rd_en.
- Stalled load: toggle load_valid 1/0 every cycle over a full texture. Expect 4096 writes, the same contents as the full-load test, and load_done only after the last beat. load_ready stays 1 throughout LOAD.
- Collision and read latency: in LOAD, read address {1,0,3} in the same cycle its beat writes 6'h3F over old 6'h00. Expect rd_val=6'h00 (read-first); a repeat read next cycle expects 6'h3F. With rd_en low, rd_valid=0 and rd_val holds.
- Ignored start: pulse load_start with load_tex=0 during LOAD of tex 1. Expect base unchanged, tex 0 untouched, and a single load_done.
- Reset mid-load: after 100 beats, hold reset_n low one cycle. Expect all outputs 0 and IDLE. Texel {1,1,35} (beat 100) retains its loaded value. A new load_start is accepted.
- With TEXTURE_RAM_FILL_EN defined: after reset, load_busy is high for 8192 cycles. Then tex0 col0 row0 = 6'h00, tex0 col32 row0 = 6'h3F, tex1 col0 row0 = 6'h3F. A read issued during FILL returns 0.
